// File: rtl/quad_pkg.sv
// Shared phase encodings, decoder state type and the quadrature
// sequence helper used by the decoder.
package quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Phase that follows ph when the encoder turns in the up direction.
  function automatic logic [1:0] phase_up(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder channels, control inputs and decoded outputs of quad_decoder.
// slave is the decoder side, master is the side that drives it.
interface quad_decoder_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 enc_a;
  logic                 enc_b;
  logic                 load_en;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 err_clr;
  logic                 ready;
  logic                 step_valid;
  logic                 step_dir;
  logic [CNT_WIDTH-1:0] position;
  logic                 wrap;
  logic                 err;

  modport master (
    output enc_a, enc_b, load_en, load_val, err_clr,
    input  ready, step_valid, step_dir, position, wrap, err
  );

  modport slave (
    input  enc_a, enc_b, load_en, load_val, err_clr,
    output ready, step_valid, step_dir, position, wrap, err
  );
endinterface

// File: rtl/quad_input_filter.sv
// One encoder channel: synchronizer chain followed by a glitch filter that
// accepts a new level only after it has persisted for FILT_LEN cycles.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    // Any cycle where the levels agree restarts the count from zero.
    if (sync_out != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;
endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive a step/direction decoder and
// a wrapping position counter with load and a sticky illegal-transition flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  quad_decoder_if.slave  bus
);
  localparam int INIT_CYCLES = SYNC_STAGES + FILT_LEN + 2;
  localparam int IW          = $clog2(INIT_CYCLES + 1);

  logic                 a_f, b_f;
  logic [1:0]           phase, diff;
  state_t               state_q, state_d;
  logic [IW-1:0]        init_cnt_q, init_cnt_d;
  logic [1:0]           prev_q, prev_d;
  logic                 ready_q, ready_d;
  logic                 step_valid_q, step_valid_d;
  logic                 step_dir_q, step_dir_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .din(bus.enc_a), .dout(a_f)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .din(bus.enc_b), .dout(b_f)
  );

  assign phase = {a_f, b_f};
  assign diff  = phase ^ prev_q;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    prev_d       = phase;
    step_valid_d = 1'b0;
    step_dir_d   = 1'b0;
    wrap_d       = 1'b0;
    err_d        = err_q;
    pos_d        = pos_q;
    // Clear first so a same-cycle illegal transition wins.
    if (bus.err_clr) err_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IW'(INIT_CYCLES - 1)) state_d = ST_TRACK;
        else init_cnt_d = init_cnt_q + IW'(1);
      end
      ST_TRACK: begin
        if (diff == 2'b11) begin
          err_d = 1'b1;
        end else if (diff != 2'b00) begin
          step_valid_d = 1'b1;
          step_dir_d   = (phase_up(prev_q) == phase);
          if (step_dir_d) begin
            pos_d  = pos_q + CNT_WIDTH'(1);
            wrap_d = &pos_q;
          end else begin
            pos_d  = pos_q - CNT_WIDTH'(1);
            wrap_d = ~|pos_q;
          end
        end
      end
    endcase
    // A load replaces the stepped value but the step is still reported.
    if (bus.load_en) begin
      pos_d  = bus.load_val;
      wrap_d = 1'b0;
    end
    ready_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      prev_q       <= 2'b00;
      ready_q      <= 1'b0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      pos_q        <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      prev_q       <= prev_d;
      ready_q      <= ready_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      pos_q        <= pos_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.step_valid = step_valid_q;
  assign bus.step_dir   = step_dir_q;
  assign bus.wrap       = wrap_q;
  assign bus.err        = err_q;
  assign bus.position   = pos_q;
endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: position counter width, minimum 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per encoder input, minimum 2.
REQ-003 SHALL have parameter FILT_LEN, default 3: stable cycles required before a filtered input changes, minimum 1.
REQ-004 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports enc_a, enc_b  input  1 each: asynchronous quadrature channels.
REQ-007 SHALL have port load_en  input  1: synchronous load of position.
REQ-008 SHALL have port load_val  input  CNT_WIDTH: value loaded when load_en=1.
REQ-009 SHALL have port err_clr  input  1: clears the sticky err flag.
REQ-010 SHALL have port ready  output  1: high in TRACK state.
REQ-011 SHALL have port step_valid  output  1: one-cycle pulse per decoded step.
REQ-012 SHALL have port step_dir  output  1: 1=up, 0=down; meaningful only when step_valid=1.
REQ-013 SHALL have port position  output  CNT_WIDTH: accumulated count.
REQ-014 SHALL have port wrap  output  1: one-cycle pulse when position wraps in either direction.
REQ-015 SHALL have port err  output  1: sticky illegal-transition flag.

Function
REQ-016 Each channel SHALL pass through SYNC_STAGES flops and then a glitch filter; the filtered value SHALL take the synchronized value only after the two have differed for FILT_LEN consecutive cycles; a shorter mismatch SHALL restart the filter count.
REQ-017 Phase SHALL be {a_f,b_f}; the up sequence SHALL be 00->01->11->10->00 and the reverse sequence SHALL be down.
REQ-018 State machine SHALL have states INIT and TRACK; reset SHALL enter INIT.
REQ-019 In INIT, prev_phase SHALL copy the filtered phase every cycle with no decoding; INIT SHALL exit to TRACK after SYNC_STAGES+FILT_LEN+2 cycles.
REQ-020 In TRACK, a one-bit phase change SHALL produce step_valid=1 for one cycle, with step_dir per REQ-017, on the edge after the filtered change; end-to-end latency from the first clk edge sampling the new enc level SHALL be SYNC_STAGES+FILT_LEN+1 edges.
REQ-021 A two-bit phase change in TRACK SHALL set err, SHALL produce no step, and SHALL update prev_phase.
REQ-022 Position SHALL be ±1 modulo 2^CNT_WIDTH on each step; up from all-ones or down from 0 SHALL pulse wrap in the same cycle as the update.
REQ-023 load_en SHALL set position=load_val on the next edge in either state and SHALL override a simultaneous step; step_valid/step_dir SHALL still report that step, and wrap SHALL stay 0.
REQ-024 err_clr SHALL clear err; when err_clr coincides with a new illegal transition, err SHALL end at 1.

Reset
REQ-025 Reset assertion SHALL immediately force: position=0, step_valid=0, step_dir=0, wrap=0, err=0, ready=0, synchronizer/filter/prev_phase=0, state=INIT, including mid-step.
REQ-026 All outputs SHALL be registered.

Structure
REQ-027 Phase encoding constants and the state enum SHALL live in shared package quad_pkg.
REQ-028 Synchronizer plus filter SHALL be sub-module quad_input_filter, instantiated once per channel.

Verification (CNT_WIDTH=8, SYNC_STAGES=2, FILT_LEN=3)
REQ-029 Release reset with enc=11 held -> ready rises after 7 cycles, no step_valid, err=0, position=0.
REQ-030 Apply 8 up transitions 00->01->11->10->00 repeated, each held 10 cycles -> 8 step_valid pulses with step_dir=1, position=8, each pulse 6 edges after its input change.
REQ-031 load 8'h01, then 2 down steps -> position 00 then FF, wrap pulses on the FF step.
REQ-032 2-cycle glitch on enc_a -> no filtered change, no step_valid, position unchanged.
REQ-033 Jump 00->11 -> err=1, no step; err_clr together with a further illegal jump 11->00 -> err stays 1; err_clr alone -> err=0.
REQ-034 load_en with load_val 8'h40 on the cycle of an up step -> position=40, step_valid=1, step_dir=1, wrap=0; reset_n pulsed mid-sequence -> all outputs 0 immediately.
